// File: rtl/bbox_extract.sv
// Bounding-box measurement over a raster-order pixel mask; reports box centre,
// size and a found flag once per frame, two edges after the frame's last pixel.
module bbox_extract #(
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576,
  parameter int MIN_PIXELS = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic       sof,
  input  logic       mask,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] width,
  output logic [9:0] height,
  output logic       found,
  output logic       out_valid
);

  typedef enum logic [1:0] {SCAN, CALC, PUBLISH} state_t;

  localparam logic [9:0]  X_LAST    = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]  Y_LAST    = 10'(IMG_HEIGHT - 1);
  localparam logic [19:0] MIN_CNT   = 20'(MIN_PIXELS);
  localparam logic [9:0]  EMPTY_MIN = 10'd1023;

  function automatic logic [9:0] centre(input logic [9:0] lo, input logic [9:0] hi);
    logic [10:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[10:1];
  endfunction

  logic [9:0]  x_cnt_q, y_cnt_q, px, py;
  logic [9:0]  min_x_q, max_x_q, min_y_q, max_y_q;
  logic [9:0]  min_x_d, max_x_d, min_y_d, max_y_d;
  logic [19:0] cnt_q, cnt_d;
  logic        frame_end;

  logic [9:0]  snap_min_x_q, snap_max_x_q, snap_min_y_q, snap_max_y_q;
  logic [19:0] snap_cnt_q;
  logic [9:0]  calc_x_q, calc_y_q, calc_w_q, calc_h_q;
  logic        calc_found_q;
  state_t      state_q;

  // Fold the current pixel into the accumulators; sof restarts them from empty.
  always_comb begin
    px        = sof ? 10'd0 : x_cnt_q;
    py        = sof ? 10'd0 : y_cnt_q;
    frame_end = in_valid && (px == X_LAST) && (py == Y_LAST);
    min_x_d   = sof ? EMPTY_MIN : min_x_q;
    max_x_d   = sof ? 10'd0     : max_x_q;
    min_y_d   = sof ? EMPTY_MIN : min_y_q;
    max_y_d   = sof ? 10'd0     : max_y_q;
    cnt_d     = sof ? 20'd0     : cnt_q;
    if (mask) begin
      if (px < min_x_d) min_x_d = px;
      if (px > max_x_d) max_x_d = px;
      if (py < min_y_d) min_y_d = py;
      if (py > max_y_d) max_y_d = py;
      if (cnt_d != '1)  cnt_d   = cnt_d + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      min_x_q      <= EMPTY_MIN;
      max_x_q      <= '0;
      min_y_q      <= EMPTY_MIN;
      max_y_q      <= '0;
      cnt_q        <= '0;
      snap_min_x_q <= EMPTY_MIN;
      snap_max_x_q <= '0;
      snap_min_y_q <= EMPTY_MIN;
      snap_max_y_q <= '0;
      snap_cnt_q   <= '0;
    end else if (in_valid) begin
      x_cnt_q <= (px == X_LAST) ? 10'd0 : px + 10'd1;
      if (px == X_LAST) y_cnt_q <= (py == Y_LAST) ? 10'd0 : py + 10'd1;
      else              y_cnt_q <= py;
      // The frame's last pixel lands in the snapshot; accumulators start over.
      if (frame_end) begin
        snap_min_x_q <= min_x_d;
        snap_max_x_q <= max_x_d;
        snap_min_y_q <= min_y_d;
        snap_max_y_q <= max_y_d;
        snap_cnt_q   <= cnt_d;
        min_x_q      <= EMPTY_MIN;
        max_x_q      <= '0;
        min_y_q      <= EMPTY_MIN;
        max_y_q      <= '0;
        cnt_q        <= '0;
      end else begin
        min_x_q <= min_x_d;
        max_x_q <= max_x_d;
        min_y_q <= min_y_d;
        max_y_q <= max_y_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SCAN;
      calc_x_q     <= '0;
      calc_y_q     <= '0;
      calc_w_q     <= '0;
      calc_h_q     <= '0;
      calc_found_q <= 1'b0;
      x            <= '0;
      y            <= '0;
      width        <= '0;
      height       <= '0;
      found        <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        SCAN: if (frame_end) state_q <= CALC;
        CALC: begin
          calc_x_q     <= centre(snap_min_x_q, snap_max_x_q);
          calc_y_q     <= centre(snap_min_y_q, snap_max_y_q);
          calc_w_q     <= snap_max_x_q - snap_min_x_q + 10'd1;
          calc_h_q     <= snap_max_y_q - snap_min_y_q + 10'd1;
          calc_found_q <= (snap_cnt_q >= MIN_CNT);
          state_q      <= PUBLISH;
        end
        PUBLISH: begin
          // A frame below threshold still pulses but leaves the box untouched.
          found     <= calc_found_q;
          out_valid <= 1'b1;
          if (calc_found_q) begin
            x      <= calc_x_q;
            y      <= calc_y_q;
            width  <= calc_w_q;
            height <= calc_h_q;
          end
          state_q <= SCAN;
        end
        default: state_q <= SCAN;
      endcase
    end
  end

endmodule
